// File: rtl/rv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv_fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM state (RUN = fetching, ERR = halted on a
//                   misaligned redirect target)
//   fetch_entry_t : one fetch buffer entry, the PC paired with its instruction
//   INSTR_BYTES   : byte stride between consecutive instructions
// -----------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous circular FIFO of fetch entries with a one-cycle flush.
// The head entry is presented combinationally from storage, so there is no
// path from the write data to the read data.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_flush    : empty the FIFO (overrides push and pop this cycle)
//   i_push     : write i_wdata at the tail (ignored when full)
//   i_wdata    : entry to write
//   i_pop      : discard the head entry (ignored when empty)
//   o_rdata    : head entry, meaningful only when o_empty = 0
//   o_full     : FIFO holds DEPTH entries
//   o_empty    : FIFO holds no entries
// -----------------------------------------------------------------------------
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    output fetch_entry_t o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_rdata  = r_mem[r_rptr];

    // Entry storage carries no reset: count decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CW'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage: drives the PC to a combinational instruction
// memory, buffers {pc, instr} pairs in order and hands them to decode over a
// valid/ready handshake. Redirects flush the buffer; misaligned redirect
// targets park the unit in ERR until an aligned redirect arrives.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   iaddr          : instruction memory byte address (current pc)
//   idata          : instruction word at iaddr, same cycle
//   redirect_valid : taken branch/jump this cycle
//   redirect_pc    : redirect target
//   out_valid      : buffer head valid
//   out_instr      : head instruction
//   out_pc         : head pc
//   out_ready      : decode accepts the head
//   misalign_err   : unit is halted in ERR
//   fetch_count    : completed output handshakes, wraps
// -----------------------------------------------------------------------------
module ifetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    fetch_state_t r_state;
    fetch_state_t w_nextState;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetchCount;

    logic         w_aligned;
    logic         w_flush;
    logic         w_loadPc;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_head;
    fetch_entry_t w_wdata;

    assign w_aligned = (redirect_pc[1:0] == 2'b00);
    assign w_wdata   = '{pc: r_pc, instr: idata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: misaligned redirect halts RUN, aligned redirect revives ERR
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            RUN: if (redirect_valid && !w_aligned) w_nextState = ERR;
            ERR: if (redirect_valid && w_aligned)  w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
    end

    // FSM outputs. A misaligned redirect seen in ERR is ignored entirely.
    // Fullness is judged on the current count, so a same-cycle pop does not
    // open a slot for a push.
    always_comb begin
        w_flush      = 1'b0;
        w_loadPc     = 1'b0;
        w_push       = 1'b0;
        misalign_err = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            RUN: begin
                w_flush   = redirect_valid;
                w_loadPc  = redirect_valid && w_aligned;
                w_push    = !redirect_valid && !w_full;
                out_valid = !w_empty;
            end
            ERR: begin
                w_flush      = redirect_valid && w_aligned;
                w_loadPc     = redirect_valid && w_aligned;
                misalign_err = 1'b1;
            end
            default: ;
        endcase
    end

    // A handshake on a redirect cycle still consumes the pre-flush head
    assign w_pop     = out_valid && out_ready;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

    // Program counter: redirect target wins over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_loadPc) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'(INSTR_BYTES);
        end
    end

    // Completed handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchCount <= '0;
        end else if (w_pop) begin
            r_fetchCount <= r_fetchCount + 32'd1;
        end
    end

    assign iaddr       = r_pc;
    assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit with a combinational instruction memory
// model. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iaddr          (iaddr),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: three real words, a tagged pattern elsewhere
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0: return 32'h03E0_0213;
            32'h4: return 32'h0010_0093;
            32'h8: return 32'h0020_8113;
            default: return addr ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign idata = memWord(iaddr);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic resetDut(input logic rdy);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, rdy);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset state
        cycle();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_iaddr", iaddr, 32'h0);
        checkOutput("rst_misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("rst_fetch_count", fetch_count, 32'd0);

        // Reset and stream
        rst_n = 1'b1;
        cycle();
        checkOutput("str0_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("str0_pc", out_pc, 32'h0);
        checkOutput("str0_instr", out_instr, 32'h03E0_0213);
        checkOutput("str0_iaddr", iaddr, 32'h4);
        cycle();
        checkOutput("str1_pc", out_pc, 32'h4);
        checkOutput("str1_instr", out_instr, 32'h0010_0093);
        checkOutput("str1_count", fetch_count, 32'd1);
        cycle();
        checkOutput("str2_pc", out_pc, 32'h8);
        checkOutput("str2_instr", out_instr, 32'h0020_8113);
        cycle();
        checkOutput("str_fetch_count", fetch_count, 32'd3);
        checkOutput("str3_pc", out_pc, 32'hC);

        // Backpressure
        resetDut(1'b0);
        repeat (5) cycle();
        checkOutput("bp_iaddr_hold", iaddr, 32'h8);
        checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_head_pc", out_pc, 32'h0);
        checkOutput("bp_no_pops", fetch_count, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();
        checkOutput("bp_pc4", out_pc, 32'h4);
        checkOutput("bp_iaddr_full_pop", iaddr, 32'h8);
        checkOutput("bp_count1", fetch_count, 32'd1);
        cycle();
        checkOutput("bp_pc8", out_pc, 32'h8);
        checkOutput("bp_instr8", out_instr, 32'h0020_8113);
        checkOutput("bp_count2", fetch_count, 32'd2);
        cycle();
        checkOutput("bp_pcC", out_pc, 32'hC);
        checkOutput("bp_count3", fetch_count, 32'd3);

        // Redirect with a handshake in the same cycle
        resetDut(1'b1);
        cycle();
        cycle();
        checkOutput("rd_head4", out_pc, 32'h4);
        checkOutput("rd_pre_count", fetch_count, 32'd1);
        applyStimulus(1'b1, 32'h40, 1'b1);
        cycle();
        checkOutput("rd_bubble", {31'b0, out_valid}, 32'd0);
        checkOutput("rd_iaddr_target", iaddr, 32'h40);
        checkOutput("rd_counted", fetch_count, 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();
        checkOutput("rd_valid_target", {31'b0, out_valid}, 32'd1);
        checkOutput("rd_pc40", out_pc, 32'h40);
        checkOutput("rd_instr40", out_instr, 32'hA5A5_0040);
        cycle();
        checkOutput("rd_pc44", out_pc, 32'h44);
        checkOutput("rd_count3", fetch_count, 32'd3);

        // Redirect while full
        applyStimulus(1'b0, 32'h0, 1'b0);
        cycle();
        checkOutput("rf_iaddr_full", iaddr, 32'h4C);
        checkOutput("rf_head44", out_pc, 32'h44);
        applyStimulus(1'b1, 32'h100, 1'b0);
        cycle();
        checkOutput("rf_flushed", {31'b0, out_valid}, 32'd0);
        checkOutput("rf_iaddr", iaddr, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0);
        cycle();
        checkOutput("rf_pc_target", out_pc, 32'h100);
        checkOutput("rf_count_same", fetch_count, 32'd3);

        // Misaligned redirect, ignored misaligned redirect in ERR, recovery
        applyStimulus(1'b1, 32'h42, 1'b0);
        cycle();
        checkOutput("ma_err", {31'b0, misalign_err}, 32'd1);
        checkOutput("ma_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("ma_pc_hold", iaddr, 32'h104);
        applyStimulus(1'b1, 32'h46, 1'b1);
        cycle();
        checkOutput("ma_ignored_err", {31'b0, misalign_err}, 32'd1);
        checkOutput("ma_ignored_pc", iaddr, 32'h104);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();
        checkOutput("ma_halt_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("ma_halt_pc", iaddr, 32'h104);
        applyStimulus(1'b1, 32'h80, 1'b0);
        cycle();
        checkOutput("ma_recover_err", {31'b0, misalign_err}, 32'd0);
        checkOutput("ma_recover_iaddr", iaddr, 32'h80);
        checkOutput("ma_recover_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        cycle();
        checkOutput("ma_pc80", out_pc, 32'h80);
        checkOutput("ma_valid80", {31'b0, out_valid}, 32'd1);
        checkOutput("ma_count", fetch_count, 32'd3);

        // Asynchronous reset between edges
        cycle();
        checkOutput("ar_pre_count", fetch_count, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("ar_iaddr", iaddr, 32'h0);
        checkOutput("ar_count", fetch_count, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
